// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - operation codes and decode helper for the multiply/divide unit
package mult_div_unit_pkg;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'd0;
  localparam md_op_t MD_MULTU = 2'd1;
  localparam md_op_t MD_DIV   = 2'd2;
  localparam md_op_t MD_DIVU  = 2'd3;

  typedef struct packed {
    logic is_div;
    logic is_signed;
  } md_ctl_t;

  function automatic md_ctl_t md_decode(input md_op_t op);
    md_ctl_t c;
    c = '0;
    case (op)
      MD_MULT:  c = '{is_div: 1'b0, is_signed: 1'b1};
      MD_MULTU: c = '{is_div: 1'b0, is_signed: 1'b0};
      MD_DIV:   c = '{is_div: 1'b1, is_signed: 1'b1};
      MD_DIVU:  c = '{is_div: 1'b1, is_signed: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - controller-side bus of the multiply/divide unit
import mult_div_unit_pkg::*;

interface mult_div_unit_if;
  logic [31:0] a;
  logic [31:0] b;
  md_op_t      md_op;
  logic        start;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  modport master (output a, b, md_op, start, wr_hi, wr_lo,
                  input  hi, lo, busy, done);
  modport slave  (input  a, b, md_op, start, wr_hi, wr_lo,
                  output hi, lo, busy, done);
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// rtl/mult_div_unit_sign_fix.sv - conditional two's-complement negation (abs value / result sign fix)
module mult_div_unit_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);
  assign y = neg ? (~x + 1'b1) : x;
endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - 33-cycle iterative MULT/MULTU/DIV/DIVU unit owning HI/LO
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  mult_div_unit_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] opr;
  logic        is_div, neg_a, neg_b;
  logic [31:0] hi_q, lo_q;
  logic        busy_q, done_q;

  md_ctl_t     ctl;
  logic        in_neg_a, in_neg_b;
  logic [31:0] abs_a, abs_b;

  assign ctl      = md_decode(bus.md_op);
  assign in_neg_a = ctl.is_signed & bus.a[31];
  assign in_neg_b = ctl.is_signed & bus.b[31];

  mult_div_unit_sign_fix #(.W(32)) u_abs_a (.x(bus.a), .neg(in_neg_a), .y(abs_a));
  mult_div_unit_sign_fix #(.W(32)) u_abs_b (.x(bus.b), .neg(in_neg_b), .y(abs_b));

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  // Divide:   acc holds {remainder, dividend shifting into quotient}.
  logic [32:0] mul_sum;
  logic [32:0] div_trial;
  logic [63:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opr} : 33'd0);
    div_trial = acc[63:31] - {1'b0, opr};
    if (is_div)
      acc_step = div_trial[32] ? {acc[62:0], 1'b0} : {div_trial[31:0], acc[30:0], 1'b1};
    else
      acc_step = {mul_sum, acc[31:1]};
  end

  logic [63:0] prod;
  logic [31:0] quo, rem;

  mult_div_unit_sign_fix #(.W(64)) u_prod (.x(acc),         .neg(neg_a ^ neg_b), .y(prod));
  mult_div_unit_sign_fix #(.W(32)) u_quo  (.x(acc[31:0]),   .neg(neg_a ^ neg_b), .y(quo));
  mult_div_unit_sign_fix #(.W(32)) u_rem  (.x(acc[63:32]),  .neg(neg_a),         .y(rem));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opr    <= '0;
      is_div <= 1'b0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state  <= S_RUN;
            busy_q <= 1'b1;
            cnt    <= '0;
            is_div <= ctl.is_div;
            neg_a  <= in_neg_a;
            neg_b  <= in_neg_b;
            opr    <= ctl.is_div ? abs_b : abs_a;
            acc    <= {32'd0, ctl.is_div ? abs_a : abs_b};
          end else begin
            if (bus.wr_hi) hi_q <= bus.a;
            if (bus.wr_lo) lo_q <= bus.a;
          end
        end
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= S_FIX;
        end
        S_FIX: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          if (is_div) begin
            // Divide by zero: remainder path already yields A; quotient forced to all ones.
            hi_q <= rem;
            lo_q <= (opr == 32'd0) ? 32'hFFFF_FFFF : quo;
          end else begin
            {hi_q, lo_q} <= prod;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS datapath. It pairs with the combinational ALU: the ALU handles single-cycle ops, and this block executes MULT, MULTU, DIV and DIVU over 33 cycles. It owns the architectural HI/LO registers. The controller starts an operation with a one-cycle START pulse, stalls while BUSY is high, and reads HI/LO (MFHI/MFLO) after DONE.

## Interface
- No parameters; data width fixed at 32.
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous, active-high reset.
- A  in  32  operand 1: multiplicand or dividend; also the MTHI/MTLO data.
- B  in  32  operand 2: multiplier or divisor.
- MD_OP  in  2  operation select, sampled with START: `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`.
- START  in  1  begin an operation; accepted only when BUSY=0.
- WR_HI  in  1  MTHI: HI <= A; honoured only when BUSY=0 and START=0.
- WR_LO  in  1  MTLO: LO <= A; same rule as WR_HI.
- HI  out  32  HI register (product high word, or remainder).
- LO  out  32  LO register (product low word, or quotient).
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse when HI/LO are updated by an operation.

## Operation
- States:
  - IDLE: accepts START, WR_HI, WR_LO.
  - RUN: 32 iterations, counter 0..31.
  - FIX: sign correction and HI/LO commit.
- IDLE + START: latch |A|, |B| (absolute values for signed ops; raw values for unsigned ops) and the sign flags. Clear the 64-bit accumulator and counter. Go to RUN.
- RUN, multiply: radix-2 shift-add. Each cycle the accumulator conditionally adds the multiplicand and shifts right by 1.
- RUN, divide: restoring division. Each cycle shift {rem, quo} left 1, trial-subtract the divisor, and keep the result if non-negative, setting quotient bit 1.
- RUN with counter=31: go to FIX.
- FIX, MULT: negate the 64-bit product if sign(A) != sign(B). HI = product[63:32], LO = product[31:0].
- FIX, DIV: quotient negated if sign(A) != sign(B); remainder takes the sign of A. LO = quotient, HI = remainder.
- FIX always asserts DONE and returns to IDLE.
- Divide by zero (DIV or DIVU, B=0): HI = A, LO = 32'hFFFFFFFF. No exception. Timing is unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. Wraps, no exception.
- START while BUSY=1: ignored. MD_OP and operands are not re-sampled.
- WR_HI/WR_LO while BUSY=1: ignored. START together with WR_HI/WR_LO in IDLE: START wins and the writes are dropped.
- HI/LO hold their values at all times except on a FIX commit, an accepted write, or reset.

## Timing
- Reset values: HI=0, LO=0, BUSY=0, DONE=0, state IDLE, counter 0.
- START sampled at edge k:
  - BUSY=1 from after edge k through edge k+33.
  - HI/LO updated at edge k+33, with DONE=1 and BUSY=0 in the following cycle.
  - Result latency: 33 cycles.
- Back-to-back: a new START is accepted in the same cycle DONE is high, giving a 34-cycle issue interval.
- WR_HI/WR_LO: HI/LO updated at the next edge, latency 1. DONE is not asserted.
- RST mid-operation: abort at that edge and apply all reset values. DONE is not asserted and no partial result reaches HI/LO.
- BUSY and DONE are registered outputs; no combinational path from inputs.

## Structure
- `MD_MULT`=2'd0, `MD_MULTU`=2'd1, `MD_DIV`=2'd2, `MD_DIVU`=2'd3 in controller_constants.vh, next to the ALU_* codes.
- State encodings IDLE/RUN/FIX are local to the module.
- One sub-module is natural: md_sign_fix. It is combinational, handling absolute value on input and conditional negation of the 64-bit result / quotient / remainder on output. It is used on both the input and output side.
- Counter is 5 bits; the datapath is a 64-bit accumulator plus a 32-bit operand register.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles DONE=1, HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 -> HI=0x00000064, LO=0xFFFFFFFF. Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Handshake and writes:
  - START again at cycle 5 of an operation -> ignored; the first result commits on schedule.
  - WR_HI with A=0x1234 while BUSY -> ignored.
  - WR_HI with A=0x1234 in IDLE -> HI=0x1234 next cycle, no DONE.
- RST asserted at cycle 10 of a MULTU -> next cycle HI=LO=0, BUSY=0, and DONE stays 0 for the following 40 cycles.
